// File: rtl/betting_round_ctrl_if.sv
// Player-facing handshake bundle for betting_round_ctrl.
// All per-player fields are packed {p2,p1}.
//   master : player side, drives valid/action/amount and sees grants, acks and bookkeeping
//   slave  : round controller side
interface betting_round_ctrl_if #(
    parameter int unsigned MONEY_W = 8
);
    logic [1:0]           p_valid;
    logic [5:0]           p_action;
    logic [2*MONEY_W-1:0] p_amount;
    logic [1:0]           p_request;
    logic [1:0]           p_ack;
    logic [1:0]           p_invalid;
    logic [5:0]           p_last_action;
    logic [2*MONEY_W-1:0] p_last_bet;
    logic [2*MONEY_W-1:0] p_commit;

    modport master (
        output p_valid, p_action, p_amount,
        input  p_request, p_ack, p_invalid, p_last_action, p_last_bet, p_commit
    );

    modport slave (
        input  p_valid, p_action, p_amount,
        output p_request, p_ack, p_invalid, p_last_action, p_last_bet, p_commit
    );
endinterface

// File: rtl/betting_round_ctrl.sv
// Sequences one two-player betting round: grants turns, validates actions,
// tracks per-player commitments and reports round end / fold to the dealer.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   round_start   pulse to begin a round (IDLE only); first_player, p_bank sampled with it
//   bus           player handshake (request/valid/action/amount, ack/invalid, last_*, commit)
//   pot_add       p1+p2 commit, valid with round_done
//   round_done    1-cycle end-of-round pulse
//   folded/winner round ended by fold and who won (held until next round_start)
//   busy          high outside IDLE
module betting_round_ctrl #(
    parameter int unsigned MONEY_W    = 8,
    parameter int unsigned MAX_RAISES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 round_start,
    input  logic                 first_player,
    input  logic [2*MONEY_W-1:0] p_bank,
    betting_round_ctrl_if.slave  bus,
    output logic [MONEY_W:0]     pot_add,
    output logic                 round_done,
    output logic                 folded,
    output logic                 winner,
    output logic                 busy
);
    localparam int unsigned RCW = $clog2(MAX_RAISES + 1);
    localparam logic [2:0] A_FOLD  = 3'd1;
    localparam logic [2:0] A_CHECK = 3'd2;
    localparam logic [2:0] A_CALL  = 3'd3;
    localparam logic [2:0] A_RAISE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_CHECK, S_REJECT, S_APPLY, S_DONE
    } state_t;

    state_t                    state;
    logic                      cur;
    logic [2:0]                act_code;
    logic [MONEY_W-1:0]        act_amt;
    logic [RCW-1:0]            raise_cnt;
    logic [1:0]                acted;
    logic [1:0]                request;
    logic [1:0]                ack;
    logic [1:0]                invalid;
    logic [1:0][2:0]           last_action;
    logic [1:0][MONEY_W-1:0]   last_bet;
    logic [1:0][MONEY_W-1:0]   commit;
    logic [1:0][MONEY_W-1:0]   bank;

    logic [1:0][2:0]           action_c;
    logic [1:0][MONEY_W-1:0]   amount_c;
    logic [1:0][MONEY_W-1:0]   bank_in_c;
    logic                      opp_c;
    logic [MONEY_W-1:0]        to_call_c;
    logic [MONEY_W-1:0]        rem_c;
    logic [MONEY_W:0]          raise_tot_c;
    logic                      legal_c;
    logic [MONEY_W-1:0]        move_c;
    logic                      finish_c;

    assign action_c           = bus.p_action;
    assign amount_c           = bus.p_amount;
    assign bank_in_c          = p_bank;
    assign bus.p_request      = request;
    assign bus.p_ack          = ack;
    assign bus.p_invalid      = invalid;
    assign bus.p_last_action  = last_action;
    assign bus.p_last_bet     = last_bet;
    assign bus.p_commit       = commit;

    // A player needs a turn unless all-in (bank fully committed) with nothing to call.
    function automatic logic needs_turn(input logic [MONEY_W-1:0] bk,
                                        input logic [MONEY_W-1:0] mine,
                                        input logic [MONEY_W-1:0] theirs);
        return (bk != mine) || (theirs > mine);
    endfunction

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Legality and money moved for the registered action of the active player.
    always_comb begin
        opp_c       = ~cur;
        to_call_c   = (commit[opp_c] > commit[cur]) ? MONEY_W'(commit[opp_c] - commit[cur]) : '0;
        rem_c       = MONEY_W'(bank[cur] - commit[cur]);
        raise_tot_c = {1'b0, to_call_c} + {1'b0, act_amt};
        legal_c     = 1'b0;
        move_c      = '0;
        case (act_code)
            A_FOLD:  legal_c = 1'b1;
            A_CHECK: legal_c = (to_call_c == '0);
            A_CALL: begin
                legal_c = (to_call_c != '0);
                move_c  = (to_call_c < rem_c) ? to_call_c : rem_c;
            end
            A_RAISE: begin
                legal_c = (raise_cnt < RCW'(MAX_RAISES)) && (act_amt != '0) &&
                          (raise_tot_c <= {1'b0, rem_c});
                move_c  = raise_tot_c[MONEY_W-1:0];
            end
            default: legal_c = 1'b0;
        endcase
        finish_c = (last_action[cur] == A_FOLD) || (last_action[cur] == A_CALL) ||
                   ((last_action[cur] == A_CHECK) && acted[opp_c]);
    end

    // Round FSM. Bookkeeping is committed on the edge into APPLY so that commits,
    // last_* and ack become visible together; the next grant is computed on the
    // edge into REQ so p_request rises the cycle after ack/invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cur         <= 1'b0;
            act_code    <= '0;
            act_amt     <= '0;
            raise_cnt   <= '0;
            acted       <= '0;
            request     <= '0;
            ack         <= '0;
            invalid     <= '0;
            last_action <= '0;
            last_bet    <= '0;
            commit      <= '0;
            bank        <= '0;
            pot_add     <= '0;
            round_done  <= 1'b0;
            folded      <= 1'b0;
            winner      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ack        <= '0;
            invalid    <= '0;
            round_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (round_start) begin
                        bank        <= bank_in_c;
                        cur         <= first_player;
                        commit      <= '0;
                        last_action <= '0;
                        last_bet    <= '0;
                        raise_cnt   <= '0;
                        acted       <= '0;
                        folded      <= 1'b0;
                        winner      <= 1'b0;
                        pot_add     <= '0;
                        busy        <= 1'b1;
                        request     <= (bank_in_c[first_player] != '0) ? onehot(first_player) : 2'b00;
                        state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (request[cur]) begin
                        state <= S_WAIT;
                    end else begin
                        // All-in with nothing to call: implicit check.
                        last_action[cur] <= A_CHECK;
                        last_bet[cur]    <= '0;
                        acted[cur]       <= 1'b1;
                        ack              <= onehot(cur);
                        state            <= S_APPLY;
                    end
                end
                S_WAIT: begin
                    if (bus.p_valid[cur]) begin
                        act_code <= action_c[cur];
                        act_amt  <= amount_c[cur];
                        request  <= '0;
                        state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (legal_c) begin
                        commit[cur]      <= MONEY_W'(commit[cur] + move_c);
                        last_action[cur] <= act_code;
                        last_bet[cur]    <= move_c;
                        acted[cur]       <= 1'b1;
                        if (act_code == A_RAISE) begin
                            raise_cnt <= RCW'(raise_cnt + RCW'(1));
                        end
                        ack   <= onehot(cur);
                        state <= S_APPLY;
                    end else begin
                        invalid <= onehot(cur);
                        state   <= S_REJECT;
                    end
                end
                S_REJECT: begin
                    request <= onehot(cur);
                    state   <= S_REQ;
                end
                S_APPLY: begin
                    if (finish_c) begin
                        folded     <= (last_action[cur] == A_FOLD);
                        winner     <= (last_action[cur] == A_FOLD) ? opp_c : 1'b0;
                        round_done <= 1'b1;
                        pot_add    <= {1'b0, commit[0]} + {1'b0, commit[1]};
                        state      <= S_DONE;
                    end else begin
                        cur     <= opp_c;
                        request <= needs_turn(bank[opp_c], commit[opp_c], commit[cur]) ?
                                   onehot(opp_c) : 2'b00;
                        state   <= S_REQ;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_betting_round_ctrl.sv
// Directed bench for betting_round_ctrl: an action model predicts each
// accept/reject and its bookkeeping, pushes it to a queue, and the queue is
// popped when the controller answers.
module tb_betting_round_ctrl;
    localparam int unsigned MW = 8;
    localparam logic [2:0] FOLD  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] CALL  = 3'd3;
    localparam logic [2:0] RAISE = 3'd4;

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  inv;
        logic [1:0]  next_req;
        logic [15:0] commit;
        logic [15:0] last_bet;
        logic [5:0]  last_act;
        logic        done;
        logic        folded;
        logic        winner;
        logic [8:0]  pot;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        round_start;
    logic        first_player;
    logic [15:0] p_bank;
    logic [8:0]  pot_add;
    logic        round_done;
    logic        folded;
    logic        winner;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];

    int m_bank[2];
    int m_commit[2];
    int m_last_bet[2];
    int m_last_act[2];
    bit m_acted[2];
    int m_raises;

    betting_round_ctrl_if #(.MONEY_W(MW)) bus();

    betting_round_ctrl #(.MONEY_W(MW), .MAX_RAISES(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .round_start  (round_start),
        .first_player (first_player),
        .p_bank       (p_bank),
        .bus          (bus),
        .pot_add      (pot_add),
        .round_done   (round_done),
        .folded       (folded),
        .winner       (winner),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] bit_of(input int pl);
        return (pl == 1) ? 2'b10 : 2'b01;
    endfunction

    // Reference behaviour of one submitted action; updates the model when accepted.
    task automatic predict(input int pl, input int code, input int amt, output exp_t e);
        int opp, tc, rem, move;
        bit legal, done, needs;
        opp   = 1 - pl;
        tc    = m_commit[opp] - m_commit[pl];
        if (tc < 0) tc = 0;
        rem   = m_bank[pl] - m_commit[pl];
        legal = 1'b0;
        move  = 0;
        if (code == 1) legal = 1'b1;
        else if (code == 2) legal = (tc == 0);
        else if (code == 3) begin legal = (tc > 0); move = (tc < rem) ? tc : rem; end
        else if (code == 4) begin legal = (m_raises < 3) && (amt > 0) && (tc + amt <= rem); move = tc + amt; end
        e = '0;
        if (legal) begin
            m_commit[pl]   += move;
            m_last_bet[pl] = move;
            m_last_act[pl] = code;
            if (code == 4) m_raises++;
            done = (code == 1) || (code == 3) || (code == 2 && m_acted[opp]);
            m_acted[pl] = 1'b1;
            e.ack    = bit_of(pl);
            e.done   = done;
            e.folded = (code == 1);
            e.winner = (code == 1) ? opp[0] : 1'b0;
            needs    = (m_bank[opp] - m_commit[opp] > 0) || (m_commit[pl] > m_commit[opp]);
            e.next_req = (!done && needs) ? bit_of(opp) : 2'b00;
        end else begin
            e.inv      = bit_of(pl);
            e.next_req = bit_of(pl);
        end
        e.commit   = {8'(m_commit[1]), 8'(m_commit[0])};
        e.last_bet = {8'(m_last_bet[1]), 8'(m_last_bet[0])};
        e.last_act = {3'(m_last_act[1]), 3'(m_last_act[0])};
        e.pot      = 9'(m_commit[0] + m_commit[1]);
    endtask

    task automatic start_round(input int first, input int b1, input int b2);
        m_bank[0] = b1; m_bank[1] = b2;
        for (int i = 0; i < 2; i++) begin
            m_commit[i] = 0; m_last_bet[i] = 0; m_last_act[i] = 0; m_acted[i] = 1'b0;
        end
        m_raises     = 0;
        round_start  = 1'b1;
        first_player = first[0];
        p_bank       = {8'(b2), 8'(b1)};
        @(negedge clk);
        round_start  = 1'b0;
        check("start_busy", busy, 1);
        check("start_commit", bus.p_commit, 0);
        check("start_folded", folded, 0);
        check("start_request", bus.p_request, bit_of(first));
    endtask

    // Submit one action for player pl and check the reply and its aftermath.
    task automatic act(input int pl, input logic [2:0] code, input int amt, input bit noise);
        exp_t e;
        int n;
        n = 0;
        while (bus.p_request !== bit_of(pl) && n < 20) begin @(negedge clk); n++; end
        check("grant", bus.p_request, bit_of(pl));
        predict(pl, code, amt, e);
        sb.push_back(e);
        bus.p_valid = bit_of(pl);
        bus.p_action[pl*3 +: 3] = code;
        bus.p_amount[pl*8 +: 8] = 8'(amt);
        if (noise) begin
            bus.p_valid = 2'b11;
            bus.p_action[(1-pl)*3 +: 3] = FOLD;
        end
        n = 0;
        do begin @(negedge clk); n++; end while (bus.p_request[pl] === 1'b1 && n < 20);
        bus.p_valid = 2'b00;
        check("capture", bus.p_request, 0);
        check("no_early_reply", {bus.p_ack, bus.p_invalid}, 0);
        @(negedge clk);
        e = sb.pop_front();
        check("ack", bus.p_ack, e.ack);
        check("invalid", bus.p_invalid, e.inv);
        check("commit", bus.p_commit, e.commit);
        check("last_bet", bus.p_last_bet, e.last_bet);
        check("last_action", bus.p_last_action, e.last_act);
        @(negedge clk);
        check("round_done", round_done, e.done);
        if (e.done) begin
            check("pot_add", pot_add, e.pot);
            check("folded", folded, e.folded);
            if (e.folded) check("winner", winner, e.winner);
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("done_pulse_end", round_done, 0);
            check("folded_held", folded, e.folded);
        end else begin
            check("next_request", bus.p_request, e.next_req);
        end
    endtask

    initial begin
        rst = 1'b1; round_start = 1'b0; first_player = 1'b0; p_bank = '0;
        bus.p_valid = '0; bus.p_action = '0; bus.p_amount = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_request", bus.p_request, 0);
        check("rst_commit", bus.p_commit, 0);
        check("rst_outputs", {round_done, folded, winner, pot_add, bus.p_ack, bus.p_invalid}, 0);
        check("rst_last", {bus.p_last_action, bus.p_last_bet}, 0);

        // Check / check
        start_round(0, 50, 50);
        act(0, CHECK, 0, 1'b0);
        act(1, CHECK, 0, 1'b0);

        // Raise / call, with a stray strobe from the idle player
        start_round(0, 50, 50);
        act(0, RAISE, 10, 1'b1);
        act(1, CALL, 0, 1'b1);

        // Short all-in call
        start_round(0, 50, 5);
        act(0, RAISE, 20, 1'b0);
        act(1, CALL, 0, 1'b0);

        // Fold
        start_round(0, 50, 50);
        act(0, CHECK, 0, 1'b0);
        act(1, FOLD, 0, 1'b0);

        // Rejections: call with nothing to call, raise cap, unknown code, oversize raise
        start_round(0, 50, 50);
        act(0, CALL, 0, 1'b0);
        act(0, RAISE, 1, 1'b0);
        act(1, RAISE, 1, 1'b0);
        act(0, RAISE, 1, 1'b0);
        act(1, RAISE, 1, 1'b0);
        act(1, 3'd5, 0, 1'b0);
        act(1, CALL, 0, 1'b0);

        start_round(1, 50, 8);
        act(1, RAISE, 9, 1'b0);
        act(1, RAISE, 0, 1'b0);
        act(1, RAISE, 8, 1'b0);
        act(0, FOLD, 0, 1'b0);

        // round_start ignored mid-round, then reset from WAIT
        start_round(0, 50, 50);
        @(negedge clk);
        round_start = 1'b1; first_player = 1'b1; p_bank = {8'd7, 8'd9};
        @(negedge clk);
        round_start = 1'b0;
        check("ignore_start_req", bus.p_request, 2'b01);
        check("ignore_start_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_request", bus.p_request, 0);
        check("midrst_outputs", {round_done, folded, winner, pot_add, bus.p_commit, bus.p_last_action}, 0);

        // Normal round after reset, P2 first
        start_round(1, 30, 30);
        act(1, CHECK, 0, 1'b0);
        act(0, CHECK, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
